// File: rtl/microseq_pkg.sv
// rtl/microseq_pkg.sv - sequencing op encodings and default sizes shared with the microcode assembler
package microseq_pkg;

  localparam logic [2:0] SEQ_NEXT     = 3'd0;
  localparam logic [2:0] SEQ_JUMP     = 3'd1;
  localparam logic [2:0] SEQ_DISPATCH = 3'd2;
  localparam logic [2:0] SEQ_BRANCH   = 3'd3;
  localparam logic [2:0] SEQ_CALL     = 3'd4;
  localparam logic [2:0] SEQ_RET      = 3'd5;
  localparam logic [2:0] SEQ_WAIT     = 3'd6;
  localparam logic [2:0] SEQ_RESTART  = 3'd7;

  localparam int DEF_OFFSET_WIDTH = 8;
  localparam int DEF_FLAG_W       = 4;
  localparam int DEF_STACK_DEPTH  = 4;

endpackage

// File: rtl/microseq_stack.sv
// rtl/microseq_stack.sv - return-address LIFO; the caller decides when push/pop are legal
module microseq_stack
  import microseq_pkg::*;
#(
  parameter int DATA_W = DEF_OFFSET_WIDTH,
  parameter int DEPTH  = DEF_STACK_DEPTH,
  localparam int DEPTH_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               res,
  input  logic               push,
  input  logic               pop,
  input  logic [DATA_W-1:0]  data_in,
  output logic [DATA_W-1:0]  top,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  mem_d [DEPTH];
  logic [DEPTH_W-1:0] depth_q;
  logic [DEPTH_W-1:0] depth_d;

  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    top     = '0;
    full    = (depth_q == DEPTH_W'(DEPTH));
    empty   = (depth_q == '0);
    // Loop compare avoids indexing the array with the wider depth counter.
    for (int i = 0; i < DEPTH; i++) begin
      if (i + 1 == int'(depth_q)) top = mem_q[i];
      if (push && i == int'(depth_q)) mem_d[i] = data_in;
    end
    if (push) depth_d = depth_q + DEPTH_W'(1);
    else if (pop) depth_d = depth_q - DEPTH_W'(1);
  end

  always_ff @(posedge clk) begin
    if (res) depth_q <= '0;
    else     depth_q <= depth_d;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign depth = depth_q;

endmodule

// File: rtl/microsequencer.sv
// rtl/microsequencer.sv - micro-PC next-address generator; return stack built only with MICROSEQ_STACK_EN
module microsequencer
  import microseq_pkg::*;
#(
  parameter int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  parameter int FLAG_W       = DEF_FLAG_W,
  parameter int STACK_DEPTH  = DEF_STACK_DEPTH,
  localparam int SEL_W   = $clog2(FLAG_W),
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic [2:0]              seq_op,
  input  logic [OFFSET_WIDTH-1:0] seq_target,
  input  logic [SEL_W-1:0]        cond_sel,
  input  logic                    cond_inv,
  input  logic [FLAG_W-1:0]       flags,
  input  logic [OFFSET_WIDTH-1:0] dispatch_addr,
  input  logic                    mem_ready,
  output logic [OFFSET_WIDTH-1:0] offset,
  output logic [OFFSET_WIDTH-1:0] upc,
  output logic [DEPTH_W-1:0]      depth,
  output logic                    stack_err,
  output logic                    waiting
);

  logic [OFFSET_WIDTH-1:0] upc_q;
  logic [OFFSET_WIDTH-1:0] upc_d;
  logic [OFFSET_WIDTH-1:0] inc;
  logic                    cond;

`ifdef MICROSEQ_STACK_EN
  logic [OFFSET_WIDTH-1:0] stk_top;
  logic                    stk_full;
  logic                    stk_empty;
  logic                    push;
  logic                    pop;
  logic                    stack_err_q;
  logic                    stack_err_d;
`endif

  always_comb begin
    inc     = upc_q + OFFSET_WIDTH'(1);
    cond    = flags[cond_sel] ^ cond_inv;
    upc_d   = inc;
    waiting = 1'b0;
`ifdef MICROSEQ_STACK_EN
    push        = 1'b0;
    pop         = 1'b0;
    stack_err_d = stack_err_q;
`endif
    case (seq_op)
      SEQ_NEXT:     upc_d = inc;
      SEQ_JUMP:     upc_d = seq_target;
      SEQ_DISPATCH: upc_d = dispatch_addr;
      SEQ_BRANCH:   upc_d = cond ? seq_target : inc;
      SEQ_CALL: begin
        upc_d = seq_target;
`ifdef MICROSEQ_STACK_EN
        // A full stack keeps its entries; the jump still happens.
        if (stk_full) stack_err_d = 1'b1;
        else          push = 1'b1;
`endif
      end
      SEQ_RET: begin
`ifdef MICROSEQ_STACK_EN
        if (stk_empty) begin
          upc_d       = '0;
          stack_err_d = 1'b1;
        end else begin
          upc_d = stk_top;
          pop   = 1'b1;
        end
`else
        upc_d = '0;
`endif
      end
      SEQ_WAIT: begin
        upc_d   = mem_ready ? inc : upc_q;
        waiting = !mem_ready;
      end
      SEQ_RESTART:  upc_d = '0;
      default:      upc_d = '0;
    endcase
    if (res) begin
      upc_d   = '0;
      waiting = 1'b0;
`ifdef MICROSEQ_STACK_EN
      push = 1'b0;
      pop  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (res) upc_q <= '0;
    else     upc_q <= upc_d;
  end

`ifdef MICROSEQ_STACK_EN
  always_ff @(posedge clk) begin
    if (res) stack_err_q <= 1'b0;
    else     stack_err_q <= stack_err_d;
  end

  microseq_stack #(
    .DATA_W (OFFSET_WIDTH),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .res     (res),
    .push    (push),
    .pop     (pop),
    .data_in (inc),
    .top     (stk_top),
    .depth   (depth),
    .full    (stk_full),
    .empty   (stk_empty)
  );

  assign stack_err = stack_err_q;
`else
  assign depth     = '0;
  assign stack_err = 1'b0;
`endif

  assign offset = upc_d;
  assign upc    = upc_q;

endmodule

// File: tb/tb_microsequencer.sv
// tb/tb_microsequencer.sv - table vectors plus call-stack and wait sequences with an upc scoreboard
module tb_microsequencer;
  import microseq_pkg::*;

`ifdef MICROSEQ_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       res;
  logic [2:0] seq_op;
  logic [7:0] seq_target;
  logic [1:0] cond_sel;
  logic       cond_inv;
  logic [3:0] flags;
  logic [7:0] dispatch_addr;
  logic       mem_ready;
  logic [7:0] offset;
  logic [7:0] upc;
  logic [2:0] depth;
  logic       stack_err;
  logic       waiting;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb[$];
  logic [7:0] mdl_stack[$];
  logic       mdl_err;

  typedef struct {
    logic       r;
    logic [2:0] op;
    logic [7:0] tgt;
    logic [1:0] cs;
    logic       ci;
    logic [3:0] fl;
    logic [7:0] da;
    logic       mr;
    logic [7:0] exp_off;
    logic       exp_wait;
  } vec_t;

  vec_t vecs[18];

  microsequencer dut (
    .clk           (clk),
    .res           (res),
    .seq_op        (seq_op),
    .seq_target    (seq_target),
    .cond_sel      (cond_sel),
    .cond_inv      (cond_inv),
    .flags         (flags),
    .dispatch_addr (dispatch_addr),
    .mem_ready     (mem_ready),
    .offset        (offset),
    .upc           (upc),
    .depth         (depth),
    .stack_err     (stack_err),
    .waiting       (waiting)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic vec_t mk(input logic r, input logic [2:0] op, input logic [7:0] tgt,
                              input logic [1:0] cs, input logic ci, input logic [3:0] fl,
                              input logic [7:0] da, input logic mr,
                              input logic [7:0] eo, input logic ew);
    vec_t v;
    v.r = r; v.op = op; v.tgt = tgt; v.cs = cs; v.ci = ci; v.fl = fl;
    v.da = da; v.mr = mr; v.exp_off = eo; v.exp_wait = ew;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string name);
    logic [7:0] e;
    res = v.r; seq_op = v.op; seq_target = v.tgt; cond_sel = v.cs; cond_inv = v.ci;
    flags = v.fl; dispatch_addr = v.da; mem_ready = v.mr;
    @(negedge clk);
    chk({name, ".offset"}, offset, v.exp_off);
    chk({name, ".waiting"}, {7'd0, waiting}, {7'd0, v.exp_wait});
    sb.push_back(v.exp_off);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({name, ".upc"}, upc, e);
    if (v.r) begin
      mdl_stack.delete();
      mdl_err = 1'b0;
    end
  endtask

  task automatic chk_state(input string name);
    chk({name, ".depth"}, {5'd0, depth}, STK ? 8'(mdl_stack.size()) : 8'd0);
    chk({name, ".stack_err"}, {7'd0, stack_err}, {7'd0, STK & mdl_err});
  endtask

  task automatic do_reset(input string name);
    step(mk(1, SEQ_NEXT, 8'h00, 0, 0, 4'h0, 8'h00, 1, 8'h00, 0), name);
  endtask

  task automatic do_jump(input logic [7:0] t, input string name);
    step(mk(0, SEQ_JUMP, t, 0, 0, 4'h0, 8'h00, 1, t, 0), name);
  endtask

  task automatic do_call(input logic [7:0] t, input string name);
    logic [7:0] ret_addr;
    ret_addr = upc + 8'd1;
    if (mdl_stack.size() < 4) mdl_stack.push_back(ret_addr);
    else mdl_err = 1'b1;
    step(mk(0, SEQ_CALL, t, 0, 0, 4'h0, 8'h00, 1, t, 0), name);
    chk_state(name);
  endtask

  task automatic do_ret(input string name);
    logic [7:0] eo;
    if (!STK) eo = 8'h00;
    else if (mdl_stack.size() == 0) begin
      eo = 8'h00;
      mdl_err = 1'b1;
    end else eo = mdl_stack.pop_back();
    step(mk(0, SEQ_RET, 8'h99, 0, 0, 4'h0, 8'h00, 1, eo, 0), name);
    chk_state(name);
  endtask

  initial begin
    mdl_err = 1'b0;
    vecs[0]  = mk(1, SEQ_WAIT,     8'h00, 0, 0, 4'h0,    8'h00, 0, 8'h00, 0);
    vecs[1]  = mk(0, SEQ_NEXT,     8'h00, 0, 0, 4'h0,    8'h00, 1, 8'h01, 0);
    vecs[2]  = mk(0, SEQ_NEXT,     8'h00, 0, 0, 4'h0,    8'h00, 1, 8'h02, 0);
    vecs[3]  = mk(1, SEQ_JUMP,     8'h40, 0, 0, 4'h0,    8'h00, 1, 8'h00, 0);
    vecs[4]  = mk(0, SEQ_JUMP,     8'h05, 0, 0, 4'h0,    8'h00, 1, 8'h05, 0);
    vecs[5]  = mk(0, SEQ_BRANCH,   8'h20, 1, 0, 4'b0010, 8'h00, 1, 8'h20, 0);
    vecs[6]  = mk(0, SEQ_JUMP,     8'h05, 0, 0, 4'h0,    8'h00, 1, 8'h05, 0);
    vecs[7]  = mk(0, SEQ_BRANCH,   8'h20, 1, 1, 4'b0010, 8'h00, 1, 8'h06, 0);
    vecs[8]  = mk(0, SEQ_BRANCH,   8'h20, 0, 0, 4'b0010, 8'h00, 1, 8'h07, 0);
    vecs[9]  = mk(0, SEQ_JUMP,     8'h10, 0, 0, 4'h0,    8'h00, 1, 8'h10, 0);
    vecs[10] = mk(0, SEQ_CALL,     8'h30, 0, 0, 4'h0,    8'h00, 1, 8'h30, 0);
    vecs[11] = mk(0, SEQ_RET,      8'h55, 0, 0, 4'h0,    8'h00, 1, STK ? 8'h11 : 8'h00, 0);
    vecs[12] = mk(0, SEQ_JUMP,     8'hFF, 0, 0, 4'h0,    8'h00, 1, 8'hFF, 0);
    vecs[13] = mk(0, SEQ_NEXT,     8'h00, 0, 0, 4'h0,    8'h00, 1, 8'h00, 0);
    vecs[14] = mk(0, SEQ_DISPATCH, 8'h33, 0, 0, 4'h0,    8'h7A, 1, 8'h7A, 0);
    vecs[15] = mk(0, SEQ_RESTART,  8'h33, 0, 0, 4'h0,    8'h7A, 1, 8'h00, 0);
    vecs[16] = mk(0, SEQ_WAIT,     8'h33, 0, 0, 4'h0,    8'h00, 1, 8'h01, 0);
    vecs[17] = mk(0, SEQ_BRANCH,   8'h44, 3, 1, 4'b0111, 8'h00, 1, 8'h44, 0);

    for (int i = 0; i < 18; i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
      if (i == 0 || i == 10 || i == 11) chk_state($sformatf("vec%0d", i));
    end

    // WAIT holds while mem_ready is low, then advances; reset wins over a holding WAIT.
    do_jump(8'h08, "wait_setup");
    for (int i = 0; i < 3; i++)
      step(mk(0, SEQ_WAIT, 8'h00, 0, 0, 4'h0, 8'h00, 0, 8'h08, 1), $sformatf("wait_hold%0d", i));
    step(mk(0, SEQ_WAIT, 8'h00, 0, 0, 4'h0, 8'h00, 1, 8'h09, 0), "wait_release");
    step(mk(0, SEQ_WAIT, 8'h00, 0, 0, 4'h0, 8'h00, 0, 8'h09, 1), "wait_again");
    step(mk(1, SEQ_WAIT, 8'h00, 0, 0, 4'h0, 8'h00, 0, 8'h00, 0), "wait_reset");

    // Nested calls past the stack depth, then unwind past empty.
    do_reset("nest_reset");
    do_jump(8'h10, "nest_jump");
    do_call(8'h20, "call1");
    do_call(8'h30, "call2");
    do_call(8'h40, "call3");
    do_call(8'h50, "call4");
    do_call(8'h60, "call5_over");
    for (int i = 0; i < 5; i++) do_ret($sformatf("ret%0d", i + 1));
    do_jump(8'h22, "sticky_jump");
    chk_state("sticky");
    do_reset("err_reset");
    chk_state("err_cleared");

    // Reset in the middle of a call chain discards the stack.
    do_jump(8'hA0, "chain_jump");
    do_call(8'hB0, "chain_call1");
    do_call(8'hC0, "chain_call2");
    do_reset("chain_reset");
    chk_state("chain_after_reset");
    do_ret("chain_ret_empty");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
